// File: rtl/rr_arb4_enc_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb4_enc_if
// Purpose  : Request/grant bundle between requesters, the round-robin
//            arbiter and the downstream 2-to-4 decoder.
// Revision : 1.0  initial release
// ============================================================================
interface rr_arb4_enc_if;
  // 'release' is a reserved word, so the consumer's end-of-grant pulse is 'rel'
  logic [3:0] req;
  logic       rel;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  // requester/consumer side
  modport master (
    output req,
    output rel,
    input  gnt_idx,
    input  gnt_vld,
    input  timeout
  );

  // arbiter side
  modport slave (
    input  req,
    input  rel,
    output gnt_idx,
    output gnt_vld,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_arb4_enc.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb4_enc
// Purpose  : Four-requester round-robin arbiter with a registered binary
//            grant index that is held until the consumer pulses 'rel'.
//            Optional forced release after MAX_HOLD cycles is enabled by
//            defining RR_ARB_TIMEOUT_EN; otherwise 'timeout' is tied low.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb4_enc #(
  parameter int MAX_HOLD = 16
) (
  input wire logic     clk,
  input wire logic     rst,
  rr_arb4_enc_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] gnt_idx, idx_nxt;
  logic       gnt_vld, vld_nxt;
  logic [2:0] pick_res;
  logic       end_grant;
  logic       forced;

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_max_hold_check
    $error("rr_arb4_enc: MAX_HOLD must be within 2..255");
  end

  // Rotating-priority search: {found, index} of the first set bit at or after base.
  // Scanning from the far end down lets the nearest hit overwrite the others.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // A grant ends on the consumer's pulse or on a forced release.
  assign end_grant = (state == GRANT) && (bus.rel || forced);

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic       timeout_q;
  logic       load;

  // A real release in the same cycle takes precedence, so no timeout then.
  assign forced = (state == GRANT) && !bus.rel && (hold_cnt == HOLD_LAST);
  assign load   = (state_nxt == GRANT) && ((state == IDLE) || end_grant);

  // Hold counter restarts on every grant load; timeout marks the forced edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= forced;
      if (load) begin
        hold_cnt <= 8'd0;
      end else if (state == GRANT) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign forced      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next-state, pointer and grant selection; grant is frozen unless it ends.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    vld_nxt   = gnt_vld;
    pick_res  = 3'b000;
    case (state)
      IDLE: begin
        pick_res = rr_pick(bus.req, ptr);
        if (pick_res[2]) begin
          state_nxt = GRANT;
          idx_nxt   = pick_res[1:0];
          vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        if (end_grant) begin
          // Priority moves to the requester just after the one being released,
          // and the same cycle re-arbitrates for a gap-free back-to-back grant.
          ptr_nxt  = gnt_idx + 2'd1;
          pick_res = rr_pick(bus.req, ptr_nxt);
          if (pick_res[2]) begin
            idx_nxt = pick_res[1:0];
          end else begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gnt_idx <= 2'd0;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= vld_nxt;
    end
  end

  assign bus.gnt_idx = gnt_idx;
  assign bus.gnt_vld = gnt_vld;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb4_enc
// Purpose  : Scoreboard bench for rr_arb4_enc. Stimulus pushes the expected
//            post-edge outputs from a queue-level reference model; a monitor
//            pops and compares after every rising edge. RR_ARB_TIMEOUT_EN
//            selects the matching reference behaviour for 'timeout'.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb4_enc;

  localparam int MAX_HOLD = 4;

  typedef struct {
    logic       vld;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  logic clk;
  logic rst;
  rr_arb4_enc_if bus();

  rr_arb4_enc #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Reference model: who owns the grant (-1 = nobody), where priority starts,
  // what index is shown, and how many cycles the grant has been held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_idx   = 0;
  int m_age   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic l, input logic rs);
    exp_t e;
    int   w;
    bit   fr;
    bit   to;
    to = 1'b0;
    fr = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_idx   = 0;
      m_age   = 0;
    end else if (m_owner < 0) begin
      w = winner(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_idx   = w;
        m_age   = 0;
      end
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      fr = !l && (m_age == MAX_HOLD - 1);
`endif
      if (l || fr) begin
        to    = fr;
        m_ptr = (m_owner + 1) % 4;
        w     = winner(r, m_ptr);
        if (w >= 0) begin
          m_owner = w;
          m_idx   = w;
          m_age   = 0;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_age++;
      end
    end
    e.vld = (m_owner >= 0);
    e.idx = 2'(m_idx);
    e.to  = to;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input logic l, input logic rs);
    @(negedge clk);
    bus.req = r;
    bus.rel = l;
    rst     = rs;
    model_step(r, l, rs);
  endtask

  // Monitor: one expectation per rising edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.gnt_vld !== e.vld) begin
          errors++;
          $display("FAIL gnt_vld t=%0t got=%b exp=%b", $time, bus.gnt_vld, e.vld);
        end
        checks++;
        if (bus.gnt_idx !== e.idx) begin
          errors++;
          $display("FAIL gnt_idx t=%0t got=%0d exp=%0d", $time, bus.gnt_idx, e.idx);
        end
        checks++;
        if (bus.timeout !== e.to) begin
          errors++;
          $display("FAIL timeout t=%0t got=%b exp=%b", $time, bus.timeout, e.to);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    rst     = 1'b1;
    bus.req = 4'b1111;
    bus.rel = 1'b0;

    // reset held two cycles with all requesters active
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);

    // rotation: all requesting, release every third cycle
    for (int i = 0; i < 15; i++) begin
      step(4'b1111, (i % 3) == 2, 1'b0);
    end

    // skip and pointer: grant 1, release to idle, then 0011 searched from 2
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);

    // hold stability: grant 2, requests change underneath, then release
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b0, 1'b0);

    // release with nothing pending, then a late requester 3
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);

    // release pulsed while idle is ignored
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // long hold without release (forced release only in the timeout build)
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(4'b0101, 1'b0, 1'b0);
    end

    // reset in the middle of a grant, with release asserted the same cycle
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b0, 1'b0);

    // single requester held high is re-granted without a gap
    for (int i = 0; i < 6; i++) begin
      step(4'b0100, i[0], 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 63) == 0));
    end

    step(4'b0000, 1'b0, 1'b0);
    stim_done = 1'b1;
  end

  // Finish once every expectation has been consumed, within a bounded wait.
  initial begin
    int waited;
    wait (stim_done);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
